// File: rtl/libv_csa_acc.sv
// libv_csa_acc: streaming multi-operand accumulator.
// Each accepted beat of N words is folded into a redundant sum/carry pair
// without carry propagation; the pair is resolved by a single carry-propagate
// add once the last beat of a packet has been absorbed.
module libv_csa_acc #(
  parameter int W      = 32,
  parameter int N      = 8,
  parameter int ACC_W  = W + 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [N-1:0][W-1:0]   in_x,
  input  logic                  in_last,
  input  logic                  in_clr,
  output logic                  in_rdy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [ACC_W-1:0]      out_sum,
  output logic [15:0]           out_beats
);

  typedef enum logic [1:0] {ACC, RES, OUT} state_t;

  state_t             state;
  logic [ACC_W-1:0]   s_r;
  logic [ACC_W-1:0]   c_r;
  logic [ACC_W-1:0]   res_r;
  logic [15:0]        beats_r;
  logic [15:0]        out_beats_r;
  logic               out_vld_r;

  logic               accept;
  logic [ACC_W-1:0]   s_nxt;
  logic [ACC_W-1:0]   c_nxt;
  logic [ACC_W-1:0]   op;
  logic [ACC_W-1:0]   s_tmp;
  logic [ACC_W-1:0]   c_tmp;
  logic [15:0]        beats_base;
  logic [15:0]        beats_nxt;

  assign in_rdy    = (state == ACC);
  assign accept    = in_vld & in_rdy;
  assign out_vld   = out_vld_r;
  assign out_sum   = res_r;
  assign out_beats = out_beats_r;

  // Carry-save reduction of the base pair plus every extended word through
  // 3:2 compressors; carries shifted past the top bit are simply lost, which
  // gives the modulo-2^ACC_W result once the pair is finally added.
  always_comb begin
    s_nxt = in_clr ? '0 : s_r;
    c_nxt = in_clr ? '0 : c_r;
    op    = '0;
    s_tmp = '0;
    c_tmp = '0;
    for (int i = 0; i < N; i++) begin
      if (SIGNED) begin
        op = ACC_W'($signed(in_x[i]));
      end else begin
        op = ACC_W'(in_x[i]);
      end
      s_tmp = s_nxt ^ c_nxt ^ op;
      c_tmp = ((s_nxt & c_nxt) | (s_nxt & op) | (c_nxt & op)) << 1;
      s_nxt = s_tmp;
      c_nxt = c_tmp;
    end
  end

  // Beat counter for the packet, restarting on a clear and sticking at 0xFFFF.
  always_comb begin
    beats_base = in_clr ? 16'd0 : beats_r;
    beats_nxt  = (beats_base == 16'hFFFF) ? beats_base : beats_base + 16'd1;
  end

  // Control FSM and all datapath registers: absorb beats in ACC, resolve the
  // redundant pair in RES, then hold the result in OUT until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACC;
      s_r         <= '0;
      c_r         <= '0;
      res_r       <= '0;
      beats_r     <= '0;
      out_beats_r <= '0;
      out_vld_r   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            s_r     <= s_nxt;
            c_r     <= c_nxt;
            beats_r <= beats_nxt;
            if (in_last) begin
              state <= RES;
            end
          end
        end
        RES: begin
          res_r       <= s_r + c_r;
          out_beats_r <= beats_r;
          s_r         <= '0;
          c_r         <= '0;
          beats_r     <= '0;
          out_vld_r   <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (out_rdy) begin
            out_vld_r <= 1'b0;
            state     <= ACC;
          end
        end
        default: begin
          out_vld_r <= 1'b0;
          state     <= ACC;
        end
      endcase
    end
  end

endmodule
